midi_tx: RTL and testbench

- MIDI transmitter: accepts complete MIDI channel or real-time messages over a valid/ready handshake and serializes them on a 31250-baud UART line (8N1, LSB first).
- Counterpart to the MIDI receiver/decoder. Drives an external MIDI OUT / thru port and provides bench loopback into the receiver.
- Includes a one-message holding buffer and optional running-status compression.

---
 rtl/midi_tx.sv | 175 +++++++++++++++++
 tb/tb_midi_tx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_tx.sv
// MIDI transmitter: one-message holding slot, optional running-status compression,
// 8N1 serializer (LSB first, idle high) at CLKS_PER_BIT clocks per bit.
module midi_tx #(
    parameter int CLKS_PER_BIT   = 1600,
    parameter bit RUNNING_STATUS = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic [7:0] i_status,
    input  logic [7:0] i_data1,
    input  logic [7:0] i_data2,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_serial,
    output logic       o_busy,
    output logic       o_err
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic            hold_full_q, hold_full_d;
    logic [7:0]      hold_st_q, hold_st_d;
    logic [7:0]      hold_d1_q, hold_d1_d;
    logic [7:0]      hold_d2_q, hold_d2_d;
    logic [1:0]      hold_len_q, hold_len_d;
    logic [2:0][7:0] act_q, act_d;
    logic [1:0]      act_len_q, act_len_d;
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      last_q, last_d;
    logic            last_vld_q, last_vld_d;
    logic            err_q, err_d;

    logic [1:0] in_len;
    logic       accept, baud_last, msg_done, transfer, hold_chan, skip_st;

    // Message length from the status byte; 0 marks a message to reject.
    always_comb begin
        in_len = 2'd0;
        case (i_status[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: in_len = 2'd3;
            4'hC, 4'hD:                   in_len = 2'd2;
            4'hF:                         in_len = i_status[3] ? 2'd1 : 2'd0;
            default:                      in_len = 2'd0;
        endcase
    end

    assign accept    = i_valid && !hold_full_q;
    assign baud_last = (baud_q == BAUD_LAST);
    assign msg_done  = (state_q == S_STOP) && baud_last && (idx_q == act_len_q - 2'd1);
    assign transfer  = hold_full_q && ((state_q == S_IDLE) || msg_done);
    assign hold_chan = (hold_len_q != 2'd1);
    assign skip_st   = RUNNING_STATUS && hold_chan && last_vld_q && (hold_st_q == last_q);

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        hold_full_d = hold_full_q;
        hold_st_d   = hold_st_q;
        hold_d1_d   = hold_d1_q;
        hold_d2_d   = hold_d2_q;
        hold_len_d  = hold_len_q;
        act_d       = act_q;
        act_len_d   = act_len_q;
        idx_d       = idx_q;
        last_d      = last_q;
        last_vld_d  = last_vld_q;
        err_d       = accept && (in_len == 2'd0);

        if (accept && in_len != 2'd0) begin
            hold_full_d = 1'b1;
            hold_st_d   = i_status;
            hold_d1_d   = {1'b0, i_data1[6:0]};
            hold_d2_d   = {1'b0, i_data2[6:0]};
            hold_len_d  = in_len;
        end else if (transfer) begin
            hold_full_d = 1'b0;
        end

        if (state_q != S_IDLE)
            baud_d = baud_last ? '0 : baud_q + 1'b1;

        case (state_q)
            S_START: if (baud_last) begin
                state_d = S_DATA;
                bit_d   = 3'd0;
            end
            S_DATA: if (baud_last) begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = S_STOP;
            end
            S_STOP: if (baud_last) begin
                if (!msg_done) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // Slot -> active message; the status byte is dropped when running status matches.
        if (transfer) begin
            state_d = S_START;
            baud_d  = '0;
            idx_d   = 2'd0;
            if (skip_st) begin
                act_d     = {8'h00, hold_d2_q, hold_d1_q};
                act_len_d = hold_len_q - 2'd1;
            end else begin
                act_d     = {hold_d2_q, hold_d1_q, hold_st_q};
                act_len_d = hold_len_q;
                if (hold_chan) begin
                    last_d     = hold_st_q;
                    last_vld_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_q       <= 3'd0;
            hold_full_q <= 1'b0;
            hold_st_q   <= 8'h00;
            hold_d1_q   <= 8'h00;
            hold_d2_q   <= 8'h00;
            hold_len_q  <= 2'd0;
            act_q       <= '0;
            act_len_q   <= 2'd0;
            idx_q       <= 2'd0;
            last_q      <= 8'h00;
            last_vld_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            hold_full_q <= hold_full_d;
            hold_st_q   <= hold_st_d;
            hold_d1_q   <= hold_d1_d;
            hold_d2_q   <= hold_d2_d;
            hold_len_q  <= hold_len_d;
            act_q       <= act_d;
            act_len_q   <= act_len_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            last_vld_q  <= last_vld_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        case (state_q)
            S_START: o_serial = 1'b0;
            S_DATA:  o_serial = act_q[idx_q][bit_q];
            default: o_serial = 1'b1;
        endcase
    end

    assign o_ready = !hold_full_q;
    assign o_busy  = (state_q != S_IDLE) || hold_full_q;
    assign o_err   = err_q;
endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: two instances (running status on / off), a UART line monitor
// per instance and a message-level reference model of the expected byte stream.
module tb_midi_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic [7:0] st = 8'h00, d1 = 8'h00, d2 = 8'h00;
    logic vA = 1'b0, vB = 1'b0;
    logic rdyA, serA, busyA, errA;
    logic rdyB, serB, busyB, errB;
    int cyc = 0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    midi_tx #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(1'b1)) dutA (
        .i_clk(clk), .i_nrst(nrst), .i_status(st), .i_data1(d1), .i_data2(d2),
        .i_valid(vA), .o_ready(rdyA), .o_serial(serA), .o_busy(busyA), .o_err(errA));
    midi_tx #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(1'b0)) dutB (
        .i_clk(clk), .i_nrst(nrst), .i_status(st), .i_data1(d1), .i_data2(d2),
        .i_valid(vB), .o_ready(rdyB), .o_serial(serB), .o_busy(busyB), .o_err(errB));

    // Received frames: {stop bit, data byte} and the cycle its start bit began.
    logic [8:0] gotA[$], gotB[$];
    int gtA[$], gtB[$];
    logic [7:0] expA[$], expB[$];
    int lastA = -1, lastB = -1;

    logic frA = 1'b0, frB = 1'b0;
    int cntA = 0, cntB = 0, tA = 0, tB = 0;
    logic [7:0] shA = 8'h00, shB = 8'h00;

    always @(negedge clk) begin
        if (!nrst) frA <= 1'b0;
        else if (!frA) begin
            if (serA === 1'b0) begin frA <= 1'b1; cntA <= 0; tA <= cyc; end
        end else begin
            cntA <= cntA + 1;
            if ((cntA + 1) >= CPB && (cntA + 1) < 9 * CPB && (cntA + 1) % CPB == CPB / 2)
                shA[3'((cntA + 1) / CPB - 1)] <= serA;
            if ((cntA + 1) == 9 * CPB + CPB / 2) begin
                gotA.push_back({serA, shA}); gtA.push_back(tA); frA <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!nrst) frB <= 1'b0;
        else if (!frB) begin
            if (serB === 1'b0) begin frB <= 1'b1; cntB <= 0; tB <= cyc; end
        end else begin
            cntB <= cntB + 1;
            if ((cntB + 1) >= CPB && (cntB + 1) < 9 * CPB && (cntB + 1) % CPB == CPB / 2)
                shB[3'((cntB + 1) / CPB - 1)] <= serB;
            if ((cntB + 1) == 9 * CPB + CPB / 2) begin
                gotB.push_back({serB, shB}); gtB.push_back(tB); frB <= 1'b0;
            end
        end
    end

    task automatic clr;
        gotA.delete(); gotB.delete(); gtA.delete(); gtB.delete();
        expA.delete(); expB.delete(); lastA = -1; lastB = -1;
    endtask

    task automatic do_reset;
        vA = 1'b0; vB = 1'b0; nrst = 1'b0;
        repeat (3) @(negedge clk);
        clr();
        nrst = 1'b1;
        @(negedge clk);
    endtask

    // Reference: message length from MIDI status rules, running status on line A only.
    task automatic model(input bit b, input logic [7:0] s, input logic [7:0] a, input logic [7:0] c,
                         output int n);
        int last;
        bit snd;
        last = b ? lastB : lastA;
        if (s < 8'h80 || (s >= 8'hF0 && s <= 8'hF7)) n = 0;
        else if (s >= 8'hF8) n = 1;
        else if (s >= 8'hC0 && s <= 8'hDF) n = 2;
        else n = 3;
        if (n == 0) return;
        snd = !(n > 1 && !b && int'(s) == last);
        if (n > 1 && snd) last = int'(s);
        if (b) begin
            if (snd) expB.push_back(s);
            if (n >= 2) expB.push_back(a & 8'h7F);
            if (n == 3) expB.push_back(c & 8'h7F);
            lastB = last;
        end else begin
            if (snd) expA.push_back(s);
            if (n >= 2) expA.push_back(a & 8'h7F);
            if (n == 3) expA.push_back(c & 8'h7F);
            lastA = last;
        end
    endtask

    // Waits for o_ready, presents one message for a single cycle; acc = cycle after acceptance.
    task automatic send(input bit b, input logic [7:0] s, input logic [7:0] a, input logic [7:0] c,
                        output int acc, output int n);
        int k = 0;
        @(negedge clk);
        while (!(b ? rdyB : rdyA) && k < 2000) begin @(negedge clk); k++; end
        total++;
        if (k >= 2000) begin bad++; $display("FAIL send_timeout line=%0d", b); end
        st = s; d1 = a; d2 = c;
        if (b) vB = 1'b1; else vA = 1'b1;
        @(posedge clk); #1;
        vA = 1'b0; vB = 1'b0;
        acc = cyc;
        model(b, s, a, c, n);
    endtask

    task automatic drain(input bit b, output int tend);
        int k = 0;
        @(negedge clk);
        while (((b ? busyB : busyA) || (b ? frB : frA)) && k < 5000) begin @(negedge clk); k++; end
        tend = cyc;
        total++;
        if (k >= 5000) begin bad++; $display("FAIL drain_timeout line=%0d", b); end
    endtask

    task automatic test_reset;
        do_reset();
        total++; if (serA !== 1'b1) begin bad++; $display("FAIL reset_serA got=%b exp=1", serA); end
        total++; if (rdyA !== 1'b1) begin bad++; $display("FAIL reset_rdyA got=%b exp=1", rdyA); end
        total++; if (busyA !== 1'b0) begin bad++; $display("FAIL reset_busyA got=%b exp=0", busyA); end
        total++; if (errA !== 1'b0) begin bad++; $display("FAIL reset_errA got=%b exp=0", errA); end
        total++; if (serB !== 1'b1) begin bad++; $display("FAIL reset_serB got=%b exp=1", serB); end
        total++; if (busyB !== 1'b0) begin bad++; $display("FAIL reset_busyB got=%b exp=0", busyB); end
    endtask

    task automatic test_note_on;
        int acc, n, tend;
        do_reset();
        send(0, 8'h90, 8'h3C, 8'h64, acc, n);
        total++; if (rdyA !== 1'b0) begin bad++; $display("FAIL note_rdy_low got=%b exp=0", rdyA); end
        @(posedge clk); #1;
        total++; if (rdyA !== 1'b1) begin bad++; $display("FAIL note_rdy_back got=%b exp=1", rdyA); end
        total++; if (serA !== 1'b0) begin bad++; $display("FAIL note_start_low got=%b exp=0", serA); end
        drain(0, tend);
        total++;
        if (gotA.size() != 3) begin bad++; $display("FAIL note_count got=%0d exp=3", gotA.size()); end
        for (int i = 0; i < expA.size() && i < gotA.size(); i++) begin
            total++;
            if (gotA[i] !== {1'b1, expA[i]}) begin
                bad++; $display("FAIL note_byte%0d got=%h exp=%h", i, gotA[i], {1'b1, expA[i]});
            end
        end
        if (gtA.size() == 3) begin
            total++; if (gtA[0] != acc + 1) begin bad++; $display("FAIL note_first_start got=%0d exp=%0d", gtA[0], acc + 1); end
            total++; if (gtA[2] != acc + 81) begin bad++; $display("FAIL note_last_start got=%0d exp=%0d", gtA[2], acc + 81); end
        end
        total++; if (tend != acc + 121) begin bad++; $display("FAIL note_busy_fall got=%0d exp=%0d", tend, acc + 121); end
    endtask

    task automatic test_back_to_back(input bit b);
        int a1, a2, n, k, r, tend;
        do_reset();
        send(b, 8'h90, 8'($urandom), 8'($urandom), a1, n);
        send(b, 8'h90, 8'h40, 8'($urandom), a2, n);
        k = 0; r = 0;
        @(negedge clk);
        while (!(b ? rdyB : rdyA) && k < 1000) begin @(negedge clk); k++; end
        r = cyc;
        total++; if (r != a1 + 121) begin bad++; $display("FAIL b2b_ready_rise line=%0d got=%0d exp=%0d", b, r, a1 + 121); end
        drain(b, tend);
        if (b) begin
            total++; if (gotB.size() != 6) begin bad++; $display("FAIL b2b_count_rs0 got=%0d exp=6", gotB.size()); end
            for (int i = 0; i < expB.size() && i < gotB.size(); i++) begin
                total++;
                if (gotB[i] !== {1'b1, expB[i]}) begin bad++; $display("FAIL b2b_rs0_byte%0d got=%h exp=%h", i, gotB[i], {1'b1, expB[i]}); end
            end
            for (int i = 1; i < gtB.size(); i++) begin
                total++;
                if (gtB[i] != gtB[0] + 40 * i) begin bad++; $display("FAIL b2b_rs0_gap%0d got=%0d exp=%0d", i, gtB[i], gtB[0] + 40 * i); end
            end
        end else begin
            total++; if (gotA.size() != 5) begin bad++; $display("FAIL b2b_count_rs1 got=%0d exp=5", gotA.size()); end
            for (int i = 0; i < expA.size() && i < gotA.size(); i++) begin
                total++;
                if (gotA[i] !== {1'b1, expA[i]}) begin bad++; $display("FAIL b2b_rs1_byte%0d got=%h exp=%h", i, gotA[i], {1'b1, expA[i]}); end
            end
            for (int i = 1; i < gtA.size(); i++) begin
                total++;
                if (gtA[i] != gtA[0] + 40 * i) begin bad++; $display("FAIL b2b_rs1_gap%0d got=%0d exp=%0d", i, gtA[i], gtA[0] + 40 * i); end
            end
        end
    endtask

    task automatic test_realtime;
        int acc, n, tend;
        do_reset();
        send(0, 8'h90, 8'($urandom), 8'($urandom), acc, n);
        send(0, 8'hF8, 8'($urandom), 8'($urandom), acc, n);
        send(0, 8'h90, 8'($urandom), 8'($urandom), acc, n);
        drain(0, tend);
        total++; if (gotA.size() != 6) begin bad++; $display("FAIL rt_count got=%0d exp=6", gotA.size()); end
        for (int i = 0; i < expA.size() && i < gotA.size(); i++) begin
            total++;
            if (gotA[i] !== {1'b1, expA[i]}) begin bad++; $display("FAIL rt_byte%0d got=%h exp=%h", i, gotA[i], {1'b1, expA[i]}); end
        end
        for (int i = 1; i < gtA.size(); i++) begin
            total++;
            if (gtA[i] != gtA[0] + 40 * i) begin bad++; $display("FAIL rt_gap%0d got=%0d exp=%0d", i, gtA[i], gtA[0] + 40 * i); end
        end
    endtask

    task automatic test_prog_err;
        int acc, n, tend;
        logic [7:0] rej [2];
        rej[0] = 8'h45; rej[1] = 8'hF0;
        do_reset();
        send(0, 8'hC5, 8'h8A, 8'h00, acc, n);
        total++; if (errA !== 1'b0) begin bad++; $display("FAIL prog_no_err got=%b exp=0", errA); end
        for (int i = 0; i < 2; i++) begin
            send(0, rej[i], 8'h11, 8'h22, acc, n);
            total++; if (errA !== 1'b1) begin bad++; $display("FAIL rej%0d_err got=%b exp=1", i, errA); end
            total++; if (rdyA !== 1'b1) begin bad++; $display("FAIL rej%0d_rdy got=%b exp=1", i, rdyA); end
            @(posedge clk); #1;
            total++; if (errA !== 1'b0) begin bad++; $display("FAIL rej%0d_pulse got=%b exp=0", i, errA); end
        end
        drain(0, tend);
        total++; if (gotA.size() != 2) begin bad++; $display("FAIL prog_count got=%0d exp=2", gotA.size()); end
        for (int i = 0; i < expA.size() && i < gotA.size(); i++) begin
            total++;
            if (gotA[i] !== {1'b1, expA[i]}) begin bad++; $display("FAIL prog_byte%0d got=%h exp=%h", i, gotA[i], {1'b1, expA[i]}); end
        end
    endtask

    task automatic test_reset_abort;
        int acc, n, tend, k;
        do_reset();
        send(0, 8'h90, 8'h3C, 8'h64, acc, n);
        k = 0;
        while (cyc < acc + 18 && k < 100) begin @(negedge clk); k++; end
        total++; if (serA !== 1'b0) begin bad++; $display("FAIL abort_bit3 got=%b exp=0", serA); end
        nrst = 1'b0; #1;
        total++; if (serA !== 1'b1) begin bad++; $display("FAIL abort_line got=%b exp=1", serA); end
        total++; if (rdyA !== 1'b1) begin bad++; $display("FAIL abort_rdy got=%b exp=1", rdyA); end
        total++; if (busyA !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busyA); end
        repeat (2) @(negedge clk);
        clr();
        nrst = 1'b1;
        send(0, 8'h90, 8'h40, 8'h7F, acc, n);
        drain(0, tend);
        total++; if (gotA.size() != 3) begin bad++; $display("FAIL abort_count got=%0d exp=3", gotA.size()); end
        for (int i = 0; i < expA.size() && i < gotA.size(); i++) begin
            total++;
            if (gotA[i] !== {1'b1, expA[i]}) begin bad++; $display("FAIL abort_byte%0d got=%h exp=%h", i, gotA[i], {1'b1, expA[i]}); end
        end
    endtask

    task automatic test_random(input bit b);
        int acc, n, tend;
        logic [7:0] s;
        logic [7:0] tbl [10];
        tbl = '{8'h90, 8'h90, 8'h80, 8'hC3, 8'hE1, 8'hF8, 8'hFE, 8'hF2, 8'h35, 8'hB7};
        do_reset();
        for (int i = 0; i < 24; i++) begin
            s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : tbl[$urandom_range(0, 9)];
            send(b, s, 8'($urandom), 8'($urandom), acc, n);
            total++;
            if ((b ? errB : errA) !== (n == 0)) begin
                bad++; $display("FAIL rnd_err line=%0d st=%h got=%b exp=%b", b, s, b ? errB : errA, n == 0);
            end
        end
        drain(b, tend);
        if (b) begin
            total++; if (gotB.size() != expB.size()) begin bad++; $display("FAIL rnd_count_rs0 got=%0d exp=%0d", gotB.size(), expB.size()); end
            for (int i = 0; i < expB.size() && i < gotB.size(); i++) begin
                total++;
                if (gotB[i] !== {1'b1, expB[i]}) begin bad++; $display("FAIL rnd_rs0_byte%0d got=%h exp=%h", i, gotB[i], {1'b1, expB[i]}); end
            end
        end else begin
            total++; if (gotA.size() != expA.size()) begin bad++; $display("FAIL rnd_count_rs1 got=%0d exp=%0d", gotA.size(), expA.size()); end
            for (int i = 0; i < expA.size() && i < gotA.size(); i++) begin
                total++;
                if (gotA[i] !== {1'b1, expA[i]}) begin bad++; $display("FAIL rnd_rs1_byte%0d got=%h exp=%h", i, gotA[i], {1'b1, expA[i]}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_realtime();
        test_prog_err();
        test_reset_abort();
        test_random(1'b0);
        test_random(1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
